// File: rtl/pcie_seq_pkg.sv
// Shared types for the PCIe reset sequencer: state encoding as shown on the LED bank.
package pcie_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_POR  = 3'd0,
        S_HOLD = 3'd1,
        S_WAIT = 3'd2,
        S_UP   = 3'd3,
        S_FAIL = 3'd4
    } seq_state_t;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module bit_sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_reset_sequencer.sv
// Drives the PCIe core reset, supervises link training with bounded retries,
// and reports link status / link-loss statistics.
module pcie_reset_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int POR_DELAY    = 10000000,
    parameter int RESET_PULSE  = 10000,
    parameter int LINK_TIMEOUT = 50000000,
    parameter int LINK_STABLE  = 1000,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               link_up,
    input  logic               restart,
    output logic               core_rst_n,
    output logic               link_ok,
    output logic               fail,
    output logic [1:0]         retry_cnt,
    output logic [7:0]         linkdown_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int STABLE_W = $clog2(LINK_STABLE) + 1;

    localparam logic [CNT_W-1:0]    POR_LAST     = CNT_W'(POR_DELAY - 1);
    localparam logic [CNT_W-1:0]    PULSE_LAST   = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LINK_STABLE - 1);
    localparam logic [1:0]          RETRY_MAX    = 2'(MAX_RETRIES);

    seq_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    hold_last;
    logic [STABLE_W-1:0] stable_cnt;
    logic                link_s;

    bit_sync_2ff u_link_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (link_up),
        .q      (link_s)
    );

    // POR and HOLD share one countdown; only the terminal count differs.
    assign hold_last = (state == S_POR) ? POR_LAST : PULSE_LAST;
    assign state_o   = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_POR;
            cnt          <= '0;
            stable_cnt   <= '0;
            core_rst_n   <= 1'b0;
            link_ok      <= 1'b0;
            fail         <= 1'b0;
            retry_cnt    <= '0;
            linkdown_cnt <= '0;
        end else if (restart && state != S_POR) begin
            state      <= S_HOLD;
            cnt        <= '0;
            retry_cnt  <= '0;
            stable_cnt <= '0;
            core_rst_n <= 1'b0;
            link_ok    <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                S_POR, S_HOLD: begin
                    if (cnt == hold_last) begin
                        state      <= S_WAIT;
                        cnt        <= '0;
                        stable_cnt <= '0;
                        core_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (!link_s) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt != STABLE_LAST) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end

                    // A link that becomes stable on the timeout cycle still counts as up.
                    if (link_s && stable_cnt == STABLE_LAST) begin
                        state     <= S_UP;
                        cnt       <= '0;
                        retry_cnt <= '0;
                        link_ok   <= 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt        <= '0;
                        core_rst_n <= 1'b0;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state     <= S_HOLD;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_UP: begin
                    if (!link_s) begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        retry_cnt  <= '0;
                        core_rst_n <= 1'b0;
                        link_ok    <= 1'b0;
                        if (linkdown_cnt != 8'hFF) begin
                            linkdown_cnt <= linkdown_cnt + 1'b1;
                        end
                    end
                end

                S_FAIL: begin
                    state <= S_FAIL;
                end

                // Unreachable encodings recover through a fresh reset pulse.
                default: begin
                    state      <= S_HOLD;
                    cnt        <= '0;
                    stable_cnt <= '0;
                    core_rst_n <= 1'b0;
                    link_ok    <= 1'b0;
                    fail       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// Randomized scoreboard bench: the stimulus predicts output-change events from the
// sequencing rules and a negedge monitor matches every observed change against them.
module tb_pcie_reset_sequencer;

    localparam int POR_DELAY    = 20;
    localparam int RESET_PULSE  = 5;
    localparam int LINK_TIMEOUT = 50;
    localparam int LINK_STABLE  = 4;
    localparam int MAX_RETRIES  = 2;

    localparam logic [2:0] ST_POR  = 3'd0;
    localparam logic [2:0] ST_HOLD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_UP   = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b1;
    logic       link_up = 1'b0;
    logic       restart = 1'b0;
    logic       core_rst_n;
    logic       link_ok;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] linkdown_cnt;
    logic [2:0] state_o;

    typedef struct packed {
        logic [2:0] st;
        logic       crn;
        logic       ok;
        logic       fl;
        logic [1:0] rc;
        logic [7:0] ld;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t v;
    } ev_t;

    ev_t   sb[$];
    ev_t   mon_ev;
    snap_t mon_snap;
    snap_t prev_snap;
    bit    armed      = 1'b0;
    int    cyc        = 0;
    int    checks     = 0;
    int    errors     = 0;
    int    exp_rc     = 0;
    int    exp_ld     = 0;
    int    wait_entry = 0;

    pcie_reset_sequencer #(
        .POR_DELAY    (POR_DELAY),
        .RESET_PULSE  (RESET_PULSE),
        .LINK_TIMEOUT (LINK_TIMEOUT),
        .LINK_STABLE  (LINK_STABLE),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .link_up      (link_up),
        .restart      (restart),
        .core_rst_n   (core_rst_n),
        .link_ok      (link_ok),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .linkdown_cnt (linkdown_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t expSnap(logic [2:0] st);
        snap_t s;
        s.st  = st;
        s.crn = (st == ST_WAIT) || (st == ST_UP);
        s.ok  = (st == ST_UP);
        s.fl  = (st == ST_FAIL);
        s.rc  = 2'(exp_rc);
        s.ld  = 8'(exp_ld);
        return s;
    endfunction

    function automatic snap_t dutSnap();
        return {state_o, core_rst_n, link_ok, fail, retry_cnt, linkdown_cnt};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic lu, input logic rs);
        link_up = lu;
        restart = rs;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expectAt(input int c, input logic [2:0] st);
        ev_t e;
        e.cyc = c;
        e.v   = expSnap(st);
        sb.push_back(e);
    endtask

    task automatic holdThenWait(input int h);
        expectAt(h, ST_HOLD);
        wait_entry = h + RESET_PULSE;
        expectAt(wait_entry, ST_WAIT);
    endtask

    // link_s sees a level set at negedge k from edge k+3 on; stability counts only inside WAIT.
    task automatic raiseLink(input int k);
        int up_at;
        waitUntil(k);
        applyStimulus(1'b1, 1'b0);
        up_at  = ((wait_entry > cyc + 2) ? wait_entry : cyc + 2) + LINK_STABLE;
        exp_rc = 0;
        expectAt(up_at, ST_UP);
        waitUntil(up_at + 1);
    endtask

    task automatic timeoutWindow(output int t);
        t = wait_entry + LINK_TIMEOUT;
        if (exp_rc == MAX_RETRIES) begin
            expectAt(t, ST_FAIL);
        end else begin
            exp_rc++;
            holdThenWait(t);
        end
    endtask

    task automatic dropLink(input int dwell, input int dur);
        int d;
        waitUntil(cyc + dwell);
        applyStimulus(1'b0, 1'b0);
        d      = cyc;
        exp_rc = 0;
        if (exp_ld < 255) exp_ld++;
        holdThenWait(d + 3);
        if (dur > 0) raiseLink(d + dur);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            mon_snap = dutSnap();
            if (mon_snap !== prev_snap) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_change", int'(mon_snap), int'(prev_snap));
                end else begin
                    mon_ev = sb.pop_front();
                    checkOutput("event_cycle", cyc, mon_ev.cyc);
                    checkOutput("event_outputs", int'(mon_snap), int'(mon_ev.v));
                end
                prev_snap = mon_snap;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int d;
        int r;
        int phase;

        $display("[TB] pcie_reset_sequencer bench starting");
        #2 resetn = 1'b0;
        #1;
        checkOutput("reset_state_o", int'(state_o), int'(ST_POR));
        checkOutput("reset_core_rst_n", int'(core_rst_n), 0);
        checkOutput("reset_link_ok", int'(link_ok), 0);
        checkOutput("reset_fail", int'(fail), 0);
        checkOutput("reset_retry_cnt", int'(retry_cnt), 0);
        checkOutput("reset_linkdown_cnt", int'(linkdown_cnt), 0);
        prev_snap = expSnap(ST_POR);
        armed     = 1'b1;

        // Power-on, then link comes up at a random point around release.
        @(negedge clk);
        resetn     = 1'b1;
        wait_entry = cyc + POR_DELAY;
        expectAt(wait_entry, ST_WAIT);
        raiseLink(wait_entry - 5 + $urandom_range(25, 0));

        // Single-cycle link drop while up.
        dropLink($urandom_range(4, 0), 1);

        // Link lost and never returns: retries exhaust into FAIL.
        dropLink($urandom_range(4, 0), 0);
        timeoutWindow(t);
        timeoutWindow(t);
        timeoutWindow(t);
        waitUntil(t + 3);

        // Restart out of FAIL, link returns shortly after.
        waitUntil(cyc + $urandom_range(5, 1));
        applyStimulus(1'b0, 1'b1);
        exp_rc = 0;
        holdThenWait(cyc + 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        raiseLink(cyc + $urandom_range(8, 0));

        // Glitchy link (3 high / 1 low) never qualifies; the window times out.
        applyStimulus(1'b0, 1'b0);
        d      = cyc;
        exp_rc = 0;
        if (exp_ld < 255) exp_ld++;
        holdThenWait(d + 3);
        timeoutWindow(t);
        phase = $urandom_range(3, 0);
        waitUntil(d + 3);
        while (cyc < t) begin
            applyStimulus(((cyc + phase) % 4) != 3, 1'b0);
            @(negedge clk);
        end
        raiseLink(t);

        // Repeated link losses drive linkdown_cnt into saturation.
        repeat (300) dropLink($urandom_range(4, 0), $urandom_range(3, 1));
        checkOutput("linkdown_saturated", int'(linkdown_cnt), exp_ld);

        // Asynchronous reset in the middle of a WAIT window.
        applyStimulus(1'b0, 1'b0);
        d      = cyc;
        exp_rc = 0;
        if (exp_ld < 255) exp_ld++;
        holdThenWait(d + 3);
        waitUntil(wait_entry + $urandom_range(40, 3));
        #1 resetn = 1'b0;
        #1;
        checkOutput("async_state_o", int'(state_o), int'(ST_POR));
        checkOutput("async_core_rst_n", int'(core_rst_n), 0);
        checkOutput("async_link_ok", int'(link_ok), 0);
        checkOutput("async_fail", int'(fail), 0);
        checkOutput("async_retry_cnt", int'(retry_cnt), 0);
        checkOutput("async_linkdown_cnt", int'(linkdown_cnt), 0);
        exp_rc = 0;
        exp_ld = 0;
        expectAt(cyc + 1, ST_POR);
        @(negedge clk);
        resetn     = 1'b1;
        r          = cyc;
        wait_entry = r + POR_DELAY;
        expectAt(wait_entry, ST_WAIT);

        // A restart during POR must not shorten the power-on delay.
        waitUntil(r + $urandom_range(15, 2));
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        raiseLink(wait_entry + $urandom_range(10, 0));

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
